// File: rtl/mmu_rsp_merge_pkg.sv
// Shared widths, response-type encodings and entry layouts for the MMU
// response merger.
package mmu_rsp_merge_pkg;

    localparam int REQ_ID_WIDTH       = 8;
    localparam int ALL_PAGE_IDX_WIDTH = 12;
    localparam int FAIL_REASON_WIDTH  = 3;
    localparam int DROP_CNT_WIDTH     = 16;

    localparam logic RSP_TYPE_ALLOC = 1'b0;
    localparam logic RSP_TYPE_FREE  = 1'b1;

    typedef struct packed {
        logic [REQ_ID_WIDTH-1:0]       id;
        logic [ALL_PAGE_IDX_WIDTH-1:0] page_idx;
        logic                          fail;
        logic [FAIL_REASON_WIDTH-1:0]  reason;
    } alloc_entry_t;

    typedef struct packed {
        logic [REQ_ID_WIDTH-1:0]      id;
        logic                         fail;
        logic [FAIL_REASON_WIDTH-1:0] reason;
    } free_entry_t;

    typedef struct packed {
        logic                          valid;
        logic                          rtype;
        logic [REQ_ID_WIDTH-1:0]       id;
        logic [ALL_PAGE_IDX_WIDTH-1:0] page_idx;
        logic                          fail;
        logic [FAIL_REASON_WIDTH-1:0]  reason;
    } rsp_reg_t;

    function automatic logic [DROP_CNT_WIDTH-1:0] sat_inc(input logic [DROP_CNT_WIDTH-1:0] cnt);
        return (&cnt) ? cnt : cnt + DROP_CNT_WIDTH'(1);
    endfunction

endpackage

// File: rtl/mmu_rsp_queue.sv
// First-word-fall-through queue: head entry is visible on dout with no read
// latency. A push to a full queue is taken only when a pop frees a slot.
module mmu_rsp_queue #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int PTR   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic [PTR:0]     count
);
    localparam logic [PTR:0] FULL_COUNT = (PTR+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR:0]     count_q, count_d;
    logic             wr_en, rd_en;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        wr_en    = push && (!full || pop);
        rd_en    = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + PTR'(1);
        if (rd_en) rd_ptr_d = rd_ptr_q + PTR'(1);
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + (PTR+1)'(1);
            2'b01:   count_d = count_q - (PTR+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state flops use non-blocking assignments so all of them update from pre-edge values.
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; count/pointers guarantee stale words are never presented.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_COUNT);
    assign count = count_q;

endmodule

// File: rtl/mmu_rsp_merge.sv
// Buffers the MMU's alloc/free response pushes and merges them round-robin
// into one registered valid/ready stream, reporting pressure and drops.
module mmu_rsp_merge
    import mmu_rsp_merge_pkg::*;
#(
    parameter int RSP_QUEUE_DEPTH = 16,
    parameter int RSP_QUEUE_PTR   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          alloc_rsp_write_en,
    input  logic [REQ_ID_WIDTH-1:0]       alloc_rsp_id,
    input  logic [ALL_PAGE_IDX_WIDTH-1:0] alloc_rsp_page_idx,
    input  logic                          alloc_rsp_fail,
    input  logic [FAIL_REASON_WIDTH-1:0]  alloc_rsp_fail_reason,
    input  logic                          free_rsp_write_en,
    input  logic [REQ_ID_WIDTH-1:0]       free_rsp_id,
    input  logic                          free_rsp_fail,
    input  logic [FAIL_REASON_WIDTH-1:0]  free_rsp_fail_reason,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic                          rsp_type,
    output logic [REQ_ID_WIDTH-1:0]       rsp_id,
    output logic [ALL_PAGE_IDX_WIDTH-1:0] rsp_page_idx,
    output logic                          rsp_fail,
    output logic [FAIL_REASON_WIDTH-1:0]  rsp_fail_reason,
    output logic                          alloc_q_afull,
    output logic                          free_q_afull,
    output logic [DROP_CNT_WIDTH-1:0]     alloc_drop_cnt,
    output logic [DROP_CNT_WIDTH-1:0]     free_drop_cnt
);
    localparam logic [RSP_QUEUE_PTR:0] AFULL_LEVEL = (RSP_QUEUE_PTR+1)'(RSP_QUEUE_DEPTH - 2);

    alloc_entry_t               alloc_din, alloc_dout;
    free_entry_t                free_din, free_dout;
    logic                       alloc_pop, alloc_empty, alloc_full;
    logic                       free_pop, free_empty, free_full;
    logic [RSP_QUEUE_PTR:0]     alloc_count, free_count;
    rsp_reg_t                   rsp_q, rsp_d;
    logic                       last_grant_q, last_grant_d;
    logic [DROP_CNT_WIDTH-1:0]  alloc_drop_cnt_q, alloc_drop_cnt_d;
    logic [DROP_CNT_WIDTH-1:0]  free_drop_cnt_q, free_drop_cnt_d;
    logic                       rsp_load, grant_alloc, grant_free;

    assign alloc_din = '{id: alloc_rsp_id, page_idx: alloc_rsp_page_idx,
                         fail: alloc_rsp_fail, reason: alloc_rsp_fail_reason};
    assign free_din  = '{id: free_rsp_id, fail: free_rsp_fail, reason: free_rsp_fail_reason};

    mmu_rsp_queue #(
        .WIDTH($bits(alloc_entry_t)), .DEPTH(RSP_QUEUE_DEPTH), .PTR(RSP_QUEUE_PTR)
    ) u_alloc_q (
        .clk(clk), .rst(rst), .push(alloc_rsp_write_en), .pop(alloc_pop),
        .din(alloc_din), .dout(alloc_dout), .empty(alloc_empty), .full(alloc_full),
        .count(alloc_count)
    );

    mmu_rsp_queue #(
        .WIDTH($bits(free_entry_t)), .DEPTH(RSP_QUEUE_DEPTH), .PTR(RSP_QUEUE_PTR)
    ) u_free_q (
        .clk(clk), .rst(rst), .push(free_rsp_write_en), .pop(free_pop),
        .din(free_din), .dout(free_dout), .empty(free_empty), .full(free_full),
        .count(free_count)
    );

    // Output register reloads when empty or being accepted; a tie goes to the side not granted last.
    always_comb begin
        rsp_load    = !rsp_q.valid || rsp_ready;
        grant_alloc = rsp_load && !alloc_empty && (free_empty || last_grant_q == RSP_TYPE_FREE);
        grant_free  = rsp_load && !free_empty && !grant_alloc;
    end

    assign alloc_pop = grant_alloc;
    assign free_pop  = grant_free;

    always_comb begin
        rsp_d            = rsp_q;
        last_grant_d     = last_grant_q;
        alloc_drop_cnt_d = alloc_drop_cnt_q;
        free_drop_cnt_d  = free_drop_cnt_q;

        if (grant_alloc) begin
            rsp_d = '{valid: 1'b1, rtype: RSP_TYPE_ALLOC, id: alloc_dout.id,
                      page_idx: alloc_dout.page_idx, fail: alloc_dout.fail,
                      reason: alloc_dout.reason};
            last_grant_d = RSP_TYPE_ALLOC;
        end else if (grant_free) begin
            rsp_d = '{valid: 1'b1, rtype: RSP_TYPE_FREE, id: free_dout.id,
                      page_idx: '0, fail: free_dout.fail, reason: free_dout.reason};
            last_grant_d = RSP_TYPE_FREE;
        end else if (rsp_load) begin
            rsp_d.valid = 1'b0;
        end

        if (alloc_rsp_write_en && alloc_full && !alloc_pop) alloc_drop_cnt_d = sat_inc(alloc_drop_cnt_q);
        if (free_rsp_write_en && free_full && !free_pop)    free_drop_cnt_d  = sat_inc(free_drop_cnt_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_q            <= '0;
            last_grant_q     <= RSP_TYPE_FREE;
            alloc_drop_cnt_q <= '0;
            free_drop_cnt_q  <= '0;
        end else begin
            rsp_q            <= rsp_d;
            last_grant_q     <= last_grant_d;
            alloc_drop_cnt_q <= alloc_drop_cnt_d;
            free_drop_cnt_q  <= free_drop_cnt_d;
        end
    end

    assign rsp_valid       = rsp_q.valid;
    assign rsp_type        = rsp_q.rtype;
    assign rsp_id          = rsp_q.id;
    assign rsp_page_idx    = rsp_q.page_idx;
    assign rsp_fail        = rsp_q.fail;
    assign rsp_fail_reason = rsp_q.reason;
    assign alloc_q_afull   = (alloc_count >= AFULL_LEVEL);
    assign free_q_afull    = (free_count >= AFULL_LEVEL);
    assign alloc_drop_cnt  = alloc_drop_cnt_q;
    assign free_drop_cnt   = free_drop_cnt_q;

endmodule

// File: tb/tb_mmu_rsp_merge.sv
// Self-checking bench for mmu_rsp_merge: directed vector table, hand-written
// corner sequences, and randomized traffic against a queue-based model.
module tb_mmu_rsp_merge;
    import mmu_rsp_merge_pkg::*;

    localparam int DEPTH = 16;

    logic                          clk = 1'b0;
    logic                          rst;
    logic                          alloc_rsp_write_en;
    logic [REQ_ID_WIDTH-1:0]       alloc_rsp_id;
    logic [ALL_PAGE_IDX_WIDTH-1:0] alloc_rsp_page_idx;
    logic                          alloc_rsp_fail;
    logic [FAIL_REASON_WIDTH-1:0]  alloc_rsp_fail_reason;
    logic                          free_rsp_write_en;
    logic [REQ_ID_WIDTH-1:0]       free_rsp_id;
    logic                          free_rsp_fail;
    logic [FAIL_REASON_WIDTH-1:0]  free_rsp_fail_reason;
    logic                          rsp_valid;
    logic                          rsp_ready;
    logic                          rsp_type;
    logic [REQ_ID_WIDTH-1:0]       rsp_id;
    logic [ALL_PAGE_IDX_WIDTH-1:0] rsp_page_idx;
    logic                          rsp_fail;
    logic [FAIL_REASON_WIDTH-1:0]  rsp_fail_reason;
    logic                          alloc_q_afull;
    logic                          free_q_afull;
    logic [DROP_CNT_WIDTH-1:0]     alloc_drop_cnt;
    logic [DROP_CNT_WIDTH-1:0]     free_drop_cnt;

    always #5 clk = ~clk;

    mmu_rsp_merge #(.RSP_QUEUE_DEPTH(DEPTH), .RSP_QUEUE_PTR(4)) dut (
        .clk(clk), .rst(rst),
        .alloc_rsp_write_en(alloc_rsp_write_en), .alloc_rsp_id(alloc_rsp_id),
        .alloc_rsp_page_idx(alloc_rsp_page_idx), .alloc_rsp_fail(alloc_rsp_fail),
        .alloc_rsp_fail_reason(alloc_rsp_fail_reason),
        .free_rsp_write_en(free_rsp_write_en), .free_rsp_id(free_rsp_id),
        .free_rsp_fail(free_rsp_fail), .free_rsp_fail_reason(free_rsp_fail_reason),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_type(rsp_type),
        .rsp_id(rsp_id), .rsp_page_idx(rsp_page_idx), .rsp_fail(rsp_fail),
        .rsp_fail_reason(rsp_fail_reason),
        .alloc_q_afull(alloc_q_afull), .free_q_afull(free_q_afull),
        .alloc_drop_cnt(alloc_drop_cnt), .free_drop_cnt(free_drop_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Reference model: two unbounded-looking queues capped at DEPTH, one output slot.
    typedef struct {
        bit          typ;
        int unsigned id;
        int unsigned page;
        bit          fail;
        int unsigned rsn;
    } rsp_t;

    rsp_t        m_aq[$];
    rsp_t        m_fq[$];
    rsp_t        m_out;
    bit          m_valid;
    bit          m_last_free;
    int unsigned m_adrop, m_fdrop;

    task automatic model_reset();
        m_aq.delete();
        m_fq.delete();
        m_valid     = 1'b0;
        m_last_free = 1'b1;
        m_adrop     = 0;
        m_fdrop     = 0;
    endtask

    // Called just after a rising edge; DUT inputs still hold their pre-edge values.
    task automatic model_edge();
        rsp_t e;
        if (rst) begin
            model_reset();
            return;
        end
        if (!m_valid || rsp_ready) begin
            if (m_aq.size() > 0 && (m_fq.size() == 0 || m_last_free)) begin
                m_out = m_aq.pop_front();
                m_valid = 1'b1;
                m_last_free = 1'b0;
            end else if (m_fq.size() > 0) begin
                m_out = m_fq.pop_front();
                m_valid = 1'b1;
                m_last_free = 1'b1;
            end else begin
                m_valid = 1'b0;
            end
        end
        if (alloc_rsp_write_en) begin
            e = '{0, alloc_rsp_id, alloc_rsp_page_idx, alloc_rsp_fail, alloc_rsp_fail_reason};
            if (m_aq.size() < DEPTH) m_aq.push_back(e);
            else if (m_adrop < 32'hFFFF) m_adrop++;
        end
        if (free_rsp_write_en) begin
            e = '{1, free_rsp_id, 0, free_rsp_fail, free_rsp_fail_reason};
            if (m_fq.size() < DEPTH) m_fq.push_back(e);
            else if (m_fdrop < 32'hFFFF) m_fdrop++;
        end
    endtask

    task automatic compare_model();
        check("rsp_valid", rsp_valid, m_valid);
        if (m_valid) begin
            check("rsp_type", rsp_type, m_out.typ);
            check("rsp_id", rsp_id, m_out.id);
            check("rsp_page_idx", rsp_page_idx, m_out.page);
            check("rsp_fail", rsp_fail, m_out.fail);
            check("rsp_fail_reason", rsp_fail_reason, m_out.rsn);
        end
        check("alloc_q_afull", alloc_q_afull, m_aq.size() >= DEPTH - 2);
        check("free_q_afull", free_q_afull, m_fq.size() >= DEPTH - 2);
        check("alloc_drop_cnt", alloc_drop_cnt, m_adrop);
        check("free_drop_cnt", free_drop_cnt, m_fdrop);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_model();
    endtask

    task automatic drive(input bit awe, input int aid, input int apage, input bit afail,
                         input int arsn, input bit fwe, input int fid, input bit ffail,
                         input int frsn);
        alloc_rsp_write_en    = awe;
        alloc_rsp_id          = aid[REQ_ID_WIDTH-1:0];
        alloc_rsp_page_idx    = apage[ALL_PAGE_IDX_WIDTH-1:0];
        alloc_rsp_fail        = afail;
        alloc_rsp_fail_reason = arsn[FAIL_REASON_WIDTH-1:0];
        free_rsp_write_en     = fwe;
        free_rsp_id           = fid[REQ_ID_WIDTH-1:0];
        free_rsp_fail         = ffail;
        free_rsp_fail_reason  = frsn[FAIL_REASON_WIDTH-1:0];
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        rsp_ready = 1'b0;
        model_reset();
        step();
        step();
        check("reset_valid", rsp_valid, 0);
        check("reset_payload", {rsp_type, rsp_id, rsp_page_idx, rsp_fail, rsp_fail_reason}, 0);
        check("reset_afull", {alloc_q_afull, free_q_afull}, 0);
        check("reset_drops", {alloc_drop_cnt, free_drop_cnt}, 0);
        rst = 1'b0;
    endtask

    typedef struct {
        bit rb;
        bit awe; int aid; int apage; bit afail; int arsn;
        bit fwe; int fid; bit ffail; int frsn;
        bit rdy;
        bit ev; bit et; int eid; int epage;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int ids[8];
        int cnt;
        int last_id;
        int push_pct;
        int rdy_pct;

        vecs[0] = '{1, 1, 5, 'h0A8, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
        vecs[1] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 5, 'h0A8};
        vecs[2] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
        vecs[3] = '{1, 1, 1, 'h033, 1, 5, 1, 2, 1, 3, 1, 0, 0, 0, 0};
        vecs[4] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 'h033};
        vecs[5] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 2, 0};
        vecs[6] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};

        do_reset();
        for (int i = 0; i < 7; i++) begin
            if (vecs[i].rb) do_reset();
            drive(vecs[i].awe, vecs[i].aid, vecs[i].apage, vecs[i].afail, vecs[i].arsn,
                  vecs[i].fwe, vecs[i].fid, vecs[i].ffail, vecs[i].frsn);
            rsp_ready = vecs[i].rdy;
            step();
            check($sformatf("vec%0d_valid", i), rsp_valid, vecs[i].ev);
            if (vecs[i].ev) begin
                check($sformatf("vec%0d_type", i), rsp_type, vecs[i].et);
                check($sformatf("vec%0d_id", i), rsp_id, vecs[i].eid);
                check($sformatf("vec%0d_page", i), rsp_page_idx, vecs[i].epage);
            end
        end

        // Sustained round-robin: fill both queues behind a stalled output, then drain.
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1, 10 + i, 16 + i, 0, 0, 1, 20 + i, 0, 0);
            step();
        end
        idle();
        step();
        ids = '{10, 20, 11, 21, 12, 22, 13, 23};
        rsp_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check($sformatf("rr%0d_valid", k), rsp_valid, 1);
            check($sformatf("rr%0d_type", k), rsp_type, k % 2);
            check($sformatf("rr%0d_id", k), rsp_id, ids[k]);
            step();
        end
        check("rr_end_valid", rsp_valid, 0);

        // Backpressure: 18 pushes into a stalled stream, last one overflows.
        rsp_ready = 1'b0;
        for (int i = 0; i < 18; i++) begin
            drive(1, 100 + i, 'h200 + i, 0, i % 8, 0, 0, 0, 0);
            step();
            check($sformatf("bp_afull%0d", i), alloc_q_afull, i >= 14);
            if (i >= 1) check($sformatf("bp_hold%0d", i), {rsp_valid, rsp_id}, {1'b1, 8'd100});
        end
        idle();
        step();
        step();
        check("bp_hold_end", {rsp_valid, rsp_id, rsp_page_idx}, {1'b1, 8'd100, 12'h200});
        check("bp_drop", alloc_drop_cnt, 1);
        rsp_ready = 1'b1;
        for (int k = 0; k < 17; k++) begin
            check($sformatf("bp_out%0d", k), {rsp_valid, rsp_id}, {1'b1, 8'(100 + k)});
            step();
        end
        check("bp_drained", rsp_valid, 0);

        // Full queue pushed while being popped: entry must be kept, no drop.
        rsp_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            drive(1, 50 + i, i, 0, 0, 0, 0, 0, 0);
            step();
        end
        check("fp_full_drop", alloc_drop_cnt, 1);
        check("fp_full_afull", alloc_q_afull, 1);
        rsp_ready = 1'b1;
        drive(1, 67, 17, 0, 0, 0, 0, 0, 0);
        step();
        idle();
        check("fp_nodrop", alloc_drop_cnt, 1);
        check("fp_head", rsp_id, 51);
        cnt = 0;
        last_id = -1;
        for (int k = 0; k < 40; k++) begin
            if (!rsp_valid) break;
            last_id = int'(rsp_id);
            cnt++;
            step();
        end
        check("fp_drain_count", cnt, 17);
        check("fp_drain_last", last_id, 67);

        // Randomized traffic with alternating light/heavy phases.
        for (int c = 0; c < 1500; c++) begin
            push_pct = ((c / 250) % 2) ? 75 : 25;
            rdy_pct  = ((c / 250) % 2) ? 40 : 85;
            drive($urandom_range(0, 99) < push_pct, $urandom, $urandom, $urandom_range(0, 1),
                  $urandom, $urandom_range(0, 99) < push_pct, $urandom, $urandom_range(0, 1),
                  $urandom);
            rsp_ready = ($urandom_range(0, 99) < rdy_pct);
            step();
        end
        idle();
        rsp_ready = 1'b1;
        repeat (40) step();
        check("rand_drained", rsp_valid, 0);

        // Reset mid-stream with a held response and three queued entries.
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1, 200 + i, i, 0, 0, 0, 0, 0, 0);
            step();
        end
        idle();
        step();
        check("mr_pre_valid", {rsp_valid, rsp_id}, {1'b1, 8'd200});
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("mr_async_valid", rsp_valid, 0);
        check("mr_async_payload", {rsp_type, rsp_id, rsp_page_idx, rsp_fail, rsp_fail_reason}, 0);
        check("mr_async_drops", {alloc_drop_cnt, free_drop_cnt}, 0);
        step();
        step();
        rst = 1'b0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            check($sformatf("mr_stale%0d", k), rsp_valid, 0);
        end
        drive(1, 7, 'h07F, 0, 0, 0, 0, 0, 0);
        step();
        idle();
        step();
        check("mr_resume", {rsp_valid, rsp_type, rsp_id}, {1'b1, 1'b0, 8'd7});
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mmu_rsp_merge.md
# mmu_rsp_merge

- Sits directly downstream of the MMU core.
- Absorbs its two push-only response ports (alloc, free), which have no backpressure, into two small first-word-fall-through queues.
- Merges them round-robin into a single valid/ready response stream tagged with response type.
- Reports queue pressure and counts responses dropped on overflow so the consumer and the bench can detect loss.

## Interface
- RSP_QUEUE_DEPTH, 16, entries per queue (power of two, ≥4)
- RSP_QUEUE_PTR, 4, log2(RSP_QUEUE_DEPTH)
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- alloc_rsp_write_en  in  1  alloc response push strobe
- alloc_rsp_id  in  `REQ_ID_WIDTH  request id
- alloc_rsp_page_idx  in  `ALL_PAGE_IDX_WIDTH  allocated page index
- alloc_rsp_fail  in  1  allocation failed
- alloc_rsp_fail_reason  in  `FAIL_REASON_WIDTH  failure code
- free_rsp_write_en  in  1  free response push strobe
- free_rsp_id  in  `REQ_ID_WIDTH  request id
- free_rsp_fail  in  1  free failed
- free_rsp_fail_reason  in  `FAIL_REASON_WIDTH  failure code
- rsp_valid  out  1  merged response valid
- rsp_ready  in  1  consumer accepts
- rsp_type  out  1  0 = alloc, 1 = free
- rsp_id  out  `REQ_ID_WIDTH  request id
- rsp_page_idx  out  `ALL_PAGE_IDX_WIDTH  page index; 0 for free responses
- rsp_fail  out  1  fail flag
- rsp_fail_reason  out  `FAIL_REASON_WIDTH  failure code
- alloc_q_afull  out  1  alloc queue count ≥ RSP_QUEUE_DEPTH-2
- free_q_afull  out  1  free queue count ≥ RSP_QUEUE_DEPTH-2
- alloc_drop_cnt  out  16  alloc responses dropped, saturating
- free_drop_cnt  out  16  free responses dropped, saturating

## Operation
- **Push.** A strobe sampled high at a rising edge writes the sideband into its queue.
  - Alloc entry: {id, page_idx, fail, reason}.
  - Free entry: {id, fail, reason}.
- **Full.** A push to a full queue is accepted only if that queue is popped in the same cycle.
  - Otherwise the entry is discarded and its drop counter increments.
  - Drop counters stick at 16'hFFFF.
- **Simultaneous pushes.** Alloc and free pushes in the same cycle are independent; both are written.
- **Output register.** A single output register holds the current response.
  - It is loadable when rsp_valid=0, or when rsp_valid=1 and rsp_ready=1.
  - On load, one non-empty queue is popped.
- **Arbitration.** Round-robin with a last_grant bit.
  - Both queues non-empty: grant the queue opposite last_grant.
  - One queue non-empty: grant it.
  - last_grant updates on every grant.
  - Reset value of last_grant is free, so alloc wins the first tie.
- **Handshake.** While rsp_valid=1 and rsp_ready=0, all rsp_* outputs hold stable and no pop occurs.
  - rsp_valid never deasserts without a handshake, except on reset.
- **afull.** alloc_q_afull and free_q_afull are combinational from the registered queue counts.
  - The threshold of DEPTH-2 covers the MMU's request-to-response pipeline, so an upstream gate on afull guarantees no drop.

## Timing
- **Reset.** While rst is high, and asynchronously on its assertion:
  - all outputs are 0;
  - queues are emptied;
  - drop counters are 0;
  - last_grant is free.
- **Reset mid-operation.** Queued and held responses are discarded, with no partial output. Operation resumes on the first edge after rst falls.
- **Latency.** A push sampled at edge E appears on rsp_valid in the cycle after edge E+1 (2-cycle latency). This holds when the queue is empty and the output register is loadable.
- **Throughput.** With rsp_ready held high, one response per cycle. The output reloads in the same cycle as acceptance.
- **Queue bypass.** There is no bypass of the queue. Minimum occupancy is 1 cycle.
- **Counter timing.** Drop counters update at the edge of the dropped push.

## Structure
- The widths `REQ_ID_WIDTH, `ALL_PAGE_IDX_WIDTH and `FAIL_REASON_WIDTH come from the shared mmu_param.vh header.
- Add these to the same header:
  - RSP_TYPE_ALLOC=1'b0 and RSP_TYPE_FREE=1'b1;
  - DROP_CNT_WIDTH=16.
- Sub-module mmu_rsp_queue is a parameterised first-word-fall-through queue.
  - Parameters: width, depth, ptr.
  - Ports: push, pop, data in/out, empty, full, count.
  - It is instantiated twice: alloc width = id+page+1+reason; free width = id+1+reason.
  - The existing sync_fifo is not used, because its registered read adds a cycle.

## Test plan
- **Single alloc.**
  - Stimulus: reset, then one alloc push (id=5, page=0x0A8, fail=0) with rsp_ready=1.
  - Expected: rsp_valid exactly 2 cycles later for one cycle; rsp_type=0, rsp_id=5, rsp_page_idx=0x0A8.
- **Same-cycle pushes.**
  - Stimulus: alloc id=1 and free id=2 pushed in the same cycle, rsp_ready=1.
  - Expected: alloc id=1 output first, free id=2 the next cycle; free response has rsp_page_idx=0.
- **Sustained round-robin.**
  - Stimulus: both queues hold 4 entries, rsp_ready=1.
  - Expected output order: A,F,A,F,A,F,A,F over 8 consecutive cycles.
- **Backpressure.**
  - Stimulus: rsp_ready=0 for 20 cycles while 18 alloc pushes arrive.
  - Expected: payload stable the whole time; alloc_q_afull asserts at count 14; alloc_drop_cnt=1 at the end.
  - Expected after releasing ready: 17 responses in push order.
- **Full with pop.**
  - Stimulus: queue full, rsp_ready=1, push coincides with a pop.
  - Expected: no drop, count unchanged.
- **Reset mid-stream.**
  - Stimulus: assert rst with 3 entries queued and rsp_valid=1.
  - Expected: rsp_valid=0 immediately; after release, no stale responses; counters 0.
